// File: rtl/spi_mpu_bridge.sv
// SPI-slave (mode 0) to 16-bit MPU bus bridge: CMD / ADDR_HI / ADDR_LO header,
// then a stream of byte-lane writes or prefetched reads with optional auto-increment.
module spi_mpu_bridge #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  spi_sck,
  input  logic                  _spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, DATA} state_t;

  typedef struct packed {
    logic                  en;
    logic                  rd;
    logic                  wr;
    logic [1:0]            be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } bus_req_t;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_d, ss_d;
  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall, ss_rise;

  logic [7:0] rx;
  logic [2:0] bitcnt;
  logic       byte_done;

  state_t     state;
  bus_req_t   breq;
  logic       is_wr, auto_inc, byte_sel, inc_pend;
  logic [7:0] addr_hi;
  logic [7:0] tx;
  logic [READ_LATENCY:1] rd_vld, rd_lane;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ~ss_s & ss_d;
  assign ss_rise  = ss_s & ~ss_d;

  assign spi_miso     = tx[7];
  assign bus_en       = breq.en;
  assign bus_rd       = breq.rd;
  assign bus_wr       = breq.wr;
  assign bus_be       = breq.be;
  assign bus_addr     = breq.addr;
  assign bus_data_out = breq.data;

  // ss resets high so leaving reset never looks like a frame start
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync[0]  <= spi_sck;
      ss_sync[0]   <= _spi_ss;
      mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sck_d <= sck_s;
      ss_d  <= ss_s;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rx        <= '0;
      bitcnt    <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss_s) begin
        bitcnt <= '0;
      end else if (sck_rise) begin
        rx        <= {rx[6:0], mosi_s};
        bitcnt    <= bitcnt + 3'd1;
        byte_done <= (bitcnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state    <= IDLE;
      breq     <= '0;
      is_wr    <= 1'b0;
      auto_inc <= 1'b0;
      byte_sel <= 1'b0;
      inc_pend <= 1'b0;
      addr_hi  <= '0;
      tx       <= '0;
      rd_vld   <= '0;
      rd_lane  <= '0;
    end else begin
      breq.en <= 1'b0;
      breq.rd <= 1'b0;
      breq.wr <= 1'b0;

      rd_vld[1]  <= breq.rd;
      rd_lane[1] <= breq.be[1];
      for (int i = 2; i <= READ_LATENCY; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_lane[i] <= rd_lane[i-1];
      end

      // write-side advance waits until the strobe cycle has shown the old address
      if (inc_pend) begin
        breq.addr <= breq.addr + ADDR_WIDTH'(1);
        inc_pend  <= 1'b0;
      end

      if (state != IDLE && ss_rise) begin
        state    <= IDLE;
        byte_sel <= 1'b0;
        rd_vld   <= '0;
      end else begin
        case (state)
          IDLE:
            if (ss_fall) state <= CMD;
          CMD:
            if (byte_done) begin
              is_wr    <= rx[7];
              auto_inc <= rx[6];
              state    <= ADDR_HI;
            end
          ADDR_HI:
            if (byte_done) begin
              addr_hi <= rx;
              state   <= ADDR_LO;
            end
          ADDR_LO:
            if (byte_done) begin
              breq.addr <= ADDR_WIDTH'({addr_hi, rx});
              byte_sel  <= 1'b0;
              state     <= DATA;
              if (!is_wr) begin
                breq.en <= 1'b1;
                breq.rd <= 1'b1;
                breq.be <= 2'b01;
              end
            end
          DATA:
            if (byte_done) begin
              byte_sel <= ~byte_sel;
              if (is_wr) begin
                breq.en   <= 1'b1;
                breq.wr   <= 1'b1;
                breq.be   <= byte_sel ? 2'b10 : 2'b01;
                breq.data <= DATA_WIDTH'({rx, rx});
                inc_pend  <= byte_sel & auto_inc;
              end else begin
                // prefetch for the next lane, so address/lane advance now
                breq.en <= 1'b1;
                breq.rd <= 1'b1;
                breq.be <= byte_sel ? 2'b01 : 2'b10;
                if (byte_sel && auto_inc) breq.addr <= breq.addr + ADDR_WIDTH'(1);
              end
            end
          default:
            state <= IDLE;
        endcase
      end

      // no shift on the byte-boundary fall, so a fresh load keeps its MSB
      if (state == DATA && !is_wr) begin
        if (rd_vld[READ_LATENCY])
          tx <= rd_lane[READ_LATENCY] ? bus_data_in[15:8] : bus_data_in[7:0];
        else if (sck_fall && bitcnt != 3'd0)
          tx <= {tx[6:0], 1'b0};
      end else begin
        tx <= '0;
      end
    end
  end
endmodule

// File: doc/spi_mpu_bridge.md
Name: spi_mpu_bridge

Overview:
- SPI-slave front end that sits directly upstream of the ChronoCube MPU-side bus.
- Converts serial byte streams from an external microcontroller into single-cycle 16-bit bus accesses (en/rd/wr/be/addr/data).
- Supports burst access with address auto-increment, so sprite X/Y and tilemap updates stream without re-addressing.

Parameters:
- ADDR_WIDTH, 16, width of bus_addr (word address).
- DATA_WIDTH, 16, width of bus data; must be 16 (two byte lanes).
- SYNC_STAGES, 2, synchronizer depth on spi_sck, _spi_ss, spi_mosi.
- READ_LATENCY, 1, clk cycles from a bus_rd pulse to valid bus_data_in.

Ports:
- clk  in  1  system clock.
- _reset  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- _spi_ss  in  1  SPI slave select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- bus_en  out  1  bus access enable (drives mpu_en).
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- bus_be  out  2  byte enables.
- bus_addr  out  ADDR_WIDTH  word address.
- bus_data_out  out  DATA_WIDTH  write data (drives mpu_data_in).
- bus_data_in  in  DATA_WIDTH  read data (from mpu_data_out).

Behaviour:
- Reset (_reset low, asynchronous):
  - All outputs 0: spi_miso=0, bus_en/rd/wr=0, bus_be=0, bus_addr=0, bus_data_out=0.
  - State IDLE; bit counter 0; byte_sel 0; tx register 0.
- Synchronization and edges:
  - sck, ss and mosi each pass through SYNC_STAGES flops.
  - Rise and fall are detected on the synchronized sck.
  - Requirement on the system: f_clk >= 8 x f_sck.
- Bit reception:
  - On each synchronized rising edge while ss is low, shift mosi into rx and increment bitcnt (3 bits).
  - The 8th rise completes a byte (bitcnt wraps to 0) and produces a one-cycle byte_done.
- Frame protocol (state machine: IDLE -> CMD -> ADDR_HI -> ADDR_LO -> DATA):
  - IDLE -> CMD on the synchronized ss falling edge.
  - CMD byte: bit7 = 1 write / 0 read; bit6 = auto-increment enable; bits5:0 ignored.
  - ADDR_HI, ADDR_LO bytes load bus_addr; byte_sel is cleared.
  - DATA: byte_sel 0 = low lane (be=01); byte_sel 1 = high lane (be=10). byte_sel toggles after every data byte.
  - Address advance: after a high-lane byte with auto-increment set, bus_addr+1 (0xFFFF wraps to 0x0000). Without auto-increment the address holds and lanes keep alternating.
- Writes:
  - On byte_done in DATA, drive bus_data_out={rx,rx} and the lane's bus_be.
  - Pulse bus_en=bus_wr=1 for exactly one clk on the cycle after byte_done.
- Reads:
  - A read is issued for the current lane one clk after ADDR_LO completes, and one clk after each DATA byte completes (prefetch).
  - Each read is a one-clk pulse of bus_en=bus_rd=1 with the lane's be.
  - Exactly READ_LATENCY clks later, capture the selected byte of bus_data_in (lane 0 = [7:0], lane 1 = [15:8]) into tx.
  - The trailing prefetch after the final byte is still issued and its data discarded. The host accepts the side effect; a high-lane read triggers a collision clear.
- MISO:
  - spi_miso = tx[7].
  - tx shifts left only on a synchronized falling edge with bitcnt != 0, so a freshly loaded MSB survives the byte-boundary fall.
  - tx is held 0 in CMD/ADDR and in write frames.
- Bus exclusivity: bus_wr and bus_rd are never both 1; bus_en is 1 only with one of them.
- Abort: synchronized ss rising mid-frame returns to IDLE, clears bitcnt/byte_sel, and issues no access for a partial byte. A pending read capture is dropped.
- Extra clocks in IDLE or with ss high are ignored.
- ss must be high for >= SYNC_STAGES+2 clks between frames.

Test Plan:
- Write 0x80,0x00,0x10,0x34,0x12 -> two bus_wr pulses at addr 0x0010: be=01 data 0x3434, then be=10 data 0x1212. Final addr 0x0010.
- Auto-increment write 0xC0,0xFF,0xFF then 4 data bytes -> writes at 0xFFFF lanes 0/1, then 0x0000 lanes 0/1.
- Read 0x40,0x02,0x00, model returns 0xBEEF after 1 clk, host clocks 2 bytes -> MISO 0xEF then 0xBE. Reads issued be=01 then be=10, plus one trailing prefetch at 0x0201 be=01.
- Read without auto-increment at 0x0005 (data 0xA55A), 4 bytes -> MISO 0x5A,0xA5,0x5A,0xA5. Address stays 0x0005.
- ss deasserted after 4 bits of a write data byte -> no bus_wr; the next frame decodes its CMD correctly.
- _reset asserted mid-read-frame -> all outputs 0 immediately (asynchronous); IDLE after release.
